// File: rtl/regbank_32_in.sv
// Write-side register bank: buffers bus writes in a 2-entry FIFO and commits one per cycle
// into R0..R3, with registered readback and a wrapping commit counter.
module regbank_32_in #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_out1x1,
    input  logic [1:0]        dr1,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic              hold,
    input  logic [1:0]        rd_sel,
    output logic [DATA_W-1:0] rd_data,
    output logic              wr_done,
    output logic [1:0]        wr_dst,
    output logic [CNT_W-1:0]  commit_cnt
);

    logic [DATA_W-1:0] regs_q [4];
    logic [DATA_W-1:0] regs_d [4];
    logic [1:0]        count_q, count_d;
    logic [DATA_W-1:0] head_data_q, head_data_d, tail_data_q, tail_data_d;
    logic [1:0]        head_dst_q, head_dst_d, tail_dst_q, tail_dst_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              wr_done_q, wr_done_d;
    logic [1:0]        wr_dst_q, wr_dst_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              push, pop;

    // Ready depends only on the registered fill level.
    assign wr_ready   = (count_q != 2'd2);
    assign push       = wr_valid && wr_ready;
    assign pop        = (count_q != 2'd0) && !hold;

    assign rd_data    = rd_data_q;
    assign wr_done    = wr_done_q;
    assign wr_dst     = wr_dst_q;
    assign commit_cnt = cnt_q;

    always_comb begin
        regs_d      = regs_q;
        count_d     = count_q;
        head_data_d = head_data_q;
        head_dst_d  = head_dst_q;
        tail_data_d = tail_data_q;
        tail_dst_d  = tail_dst_q;
        wr_done_d   = 1'b0;
        wr_dst_d    = wr_dst_q;
        cnt_d       = cnt_q;
        rd_data_d   = regs_q[rd_sel];

        if (pop) begin
            regs_d[head_dst_q] = head_data_q;
            wr_done_d          = 1'b1;
            wr_dst_d           = head_dst_q;
            cnt_d              = cnt_q + CNT_W'(1);
        end

        case (count_q)
            2'd0: begin
                if (push) begin
                    head_data_d = data_out1x1;
                    head_dst_d  = dr1;
                    count_d     = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_data_d = data_out1x1;
                    head_dst_d  = dr1;
                end else if (pop) begin
                    count_d = 2'd0;
                end else if (push) begin
                    tail_data_d = data_out1x1;
                    tail_dst_d  = dr1;
                    count_d     = 2'd2;
                end
            end
            default: begin
                if (pop) begin
                    head_data_d = tail_data_q;
                    head_dst_d  = tail_dst_q;
                    count_d     = 2'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
            count_q     <= 2'd0;
            head_data_q <= '0;
            head_dst_q  <= 2'd0;
            tail_data_q <= '0;
            tail_dst_q  <= 2'd0;
            rd_data_q   <= '0;
            wr_done_q   <= 1'b0;
            wr_dst_q    <= 2'd0;
            cnt_q       <= '0;
        end else begin
            for (int i = 0; i < 4; i++) regs_q[i] <= regs_d[i];
            count_q     <= count_d;
            head_data_q <= head_data_d;
            head_dst_q  <= head_dst_d;
            tail_data_q <= tail_data_d;
            tail_dst_q  <= tail_dst_d;
            rd_data_q   <= rd_data_d;
            wr_done_q   <= wr_done_d;
            wr_dst_q    <= wr_dst_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule
